// File: rtl/delay_tap_buffer_pkg.sv
// Shared definitions for the delay_tap_buffer slice.
// Holds the default geometry (data width, stage count, tap-select width) and a
// ceil-log2 helper so the top and stage modules agree on sizing.
// No ports.
package delay_tap_buffer_pkg;

    localparam int unsigned DefWidth = 8;
    localparam int unsigned DefDepth = 4;
    localparam int unsigned DefTapW  = 2;

    // Ceil-log2 usable in constant expressions; returns 1 for values <= 2.
    function automatic int unsigned clog2_f(input int unsigned value);
        int unsigned res;
        res = 1;
        while ((32'd1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

    // Minimum tap-select width that can address every stage.
    localparam int unsigned DefMinTapW = clog2_f(DefDepth);

endpackage

// File: rtl/delay_tap_buffer_stage.sv
// One WIDTH-bit stage of the delay line.
// Priority on each rising edge: reset > clr > en > hold.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset, clears the stage
//   clr   - synchronous flush, same effect as reset
//   en    - load d when high, hold otherwise
//   d     - data from the previous stage (or the line input)
//   q     - registered stage contents
module delay_tap_buffer_stage
    import delay_tap_buffer_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (reset || clr) begin
            data_d = '0;
        end else if (en) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign q = data_q;

endmodule

// File: rtl/delay_tap_buffer.sv
// WIDTH-bit, DEPTH-stage delay line with shift enable, synchronous flush,
// runtime-selectable output tap and fill tracking.
// Optional build macro DELAY_TAP_BUFFER_EDGE_DET_EN enables per-bit edge
// detection across the first two stages; when undefined rise/fall are tied 0.
// Ports:
//   clk     - rising-edge clock
//   reset   - synchronous active-high reset
//   en      - shift enable
//   clr     - synchronous flush (same effect as reset)
//   in      - data entering stage 0
//   tap_sel - output stage select (0 = 1-cycle delay), clamped to DEPTH-1
//   out     - contents of the selected stage
//   buff    - contents of stage 0
//   valid   - selected stage holds data shifted in since the last flush
//   fill    - shifts since flush, saturating at DEPTH
//   rise    - per-bit 0->1 edge between stage 1 and stage 0
//   fall    - per-bit 1->0 edge between stage 1 and stage 0
module delay_tap_buffer
    import delay_tap_buffer_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned DEPTH = DefDepth,
    parameter int unsigned TAP_W = DefTapW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] in,
    input  logic [TAP_W-1:0] tap_sel,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] buff,
    output logic             valid,
    output logic [TAP_W:0]   fill,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam logic [TAP_W:0]   FillMax = (TAP_W+1)'(DEPTH);
    localparam logic [TAP_W:0]   FillTwo = (TAP_W+1)'(2);
    localparam logic [TAP_W-1:0] MaxTap  = TAP_W'(DEPTH - 1);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [TAP_W:0]   fill_d;
    logic [TAP_W:0]   fill_q;
    logic [TAP_W-1:0] tap_idx;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] stage_in;
        if (k == 0) begin : g_head
            assign stage_in = in;
        end else begin : g_body
            assign stage_in = stage_q[k-1];
        end
        delay_tap_buffer_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk   (clk),
            .reset (reset),
            .clr   (clr),
            .en    (en),
            .d     (stage_in),
            .q     (stage_q[k])
        );
    end

    // Fill counts enabled shifts since the last flush and sticks at DEPTH.
    always_comb begin
        fill_d = fill_q;
        if (reset || clr) begin
            fill_d = '0;
        end else if (en && (fill_q != FillMax)) begin
            fill_d = fill_q + {{TAP_W{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        fill_q <= fill_d;
    end

    // Clamp handles a non-power-of-2 DEPTH where tap_sel can exceed the last stage.
    always_comb begin
        tap_idx = (tap_sel > MaxTap) ? MaxTap : tap_sel;
    end

    assign out   = stage_q[tap_idx];
    assign buff  = stage_q[0];
    assign fill  = fill_q;
    assign valid = (fill_q > {1'b0, tap_idx});

`ifdef DELAY_TAP_BUFFER_EDGE_DET_EN
    // Edges are only meaningful once both compared stages hold real data.
    always_comb begin
        rise = '0;
        fall = '0;
        if (fill_q >= FillTwo) begin
            rise = stage_q[0] & ~stage_q[1];
            fall = ~stage_q[0] & stage_q[1];
        end
    end
`else
    assign rise = '0;
    assign fall = '0;
`endif

endmodule
